// File: rtl/processor_switcher.sv
// Grants the shared memory, GPU and interrupt ports to one processor at a time, with a drained handover and a sticky fatal halt.
// Optional build macro PROC_WATCHDOG_EN adds an inactivity watchdog while a processor runs.
module processor_switcher #(
   parameter int NUM_PROC     = 4,
   parameter int ID_W         = 2,
   parameter int BOOT_ID      = 0,
   parameter int DRAIN_CYCLES = 2,
   parameter int WDT_CYCLES   = 65536
) (
   input  logic                     CLK,
   input  logic                     RESET,
   output logic [NUM_PROC-1:0]      PROC_ENABLE,
   input  logic [NUM_PROC-1:0]      PROC_SWITCH_REQ,
   input  logic [NUM_PROC*ID_W-1:0] PROC_SWITCH_TGT,
   input  logic [NUM_PROC-1:0]      PROC_FATAL,
   input  logic [NUM_PROC-1:0]      PROC_MEM_ENABLE,
   input  logic [NUM_PROC-1:0]      PROC_MEM_WRITE,
   input  logic [NUM_PROC*16-1:0]   PROC_MEM_ADDR,
   input  logic [NUM_PROC*16-1:0]   PROC_MEM_DATA_W,
   output logic                     MEM_ENABLE,
   output logic                     MEM_WRITE,
   output logic [15:0]              MEM_ADDR,
   output logic [15:0]              MEM_DATA_W,
   input  logic [NUM_PROC-1:0]      PROC_GPU_DRAW,
   output logic                     GPU_DRAW,
   input  logic [NUM_PROC-1:0]      PROC_INT_IACK,
   input  logic [NUM_PROC-1:0]      PROC_INT_IEND,
   output logic                     INT_IACK,
   output logic                     INT_IEND,
   output logic                     IRQ_HOLD,
   output logic [ID_W-1:0]          ACTIVE_ID,
   output logic                     HALTED,
   output logic [ID_W-1:0]          ERROR_ID,
   output logic [2:0]               STATE_DBG
);
   typedef enum logic [2:0] {ST_BOOT, ST_RUN, ST_DRAIN, ST_SWAP, ST_HALT} state_t;

   if (NUM_PROC < 2 || NUM_PROC > 4 || DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 ||
       WDT_CYCLES < 1 || WDT_CYCLES > 131071) begin : g_bad_param
      $error("processor_switcher: parameter out of range");
   end

   state_t              state_q, state_d;
   logic [ID_W-1:0]     active_q, active_d, tgt_q, tgt_d, error_q, error_d;
   logic [3:0]          drain_q, drain_d;
   logic                open_q, open_d;
   logic [NUM_PROC-1:0] enable_q;
   logic                wdt_hit;

   // Selected signals from the active processor's slice
   logic            act_req, act_fatal, act_mem_en, act_mem_wr, act_draw, act_iack, act_iend;
   logic [ID_W-1:0] act_tgt;
   logic [15:0]     act_addr, act_data;

   always_comb begin
      act_req    = 1'b0;
      act_fatal  = 1'b0;
      act_mem_en = 1'b0;
      act_mem_wr = 1'b0;
      act_draw   = 1'b0;
      act_iack   = 1'b0;
      act_iend   = 1'b0;
      act_tgt    = '0;
      act_addr   = '0;
      act_data   = '0;
      for (int i = 0; i < NUM_PROC; i++) begin
         if (active_q == ID_W'(i)) begin
            act_req    = PROC_SWITCH_REQ[i];
            act_fatal  = PROC_FATAL[i];
            act_mem_en = PROC_MEM_ENABLE[i];
            act_mem_wr = PROC_MEM_WRITE[i];
            act_draw   = PROC_GPU_DRAW[i];
            act_iack   = PROC_INT_IACK[i];
            act_iend   = PROC_INT_IEND[i];
            act_tgt    = PROC_SWITCH_TGT[i*ID_W +: ID_W];
            act_addr   = PROC_MEM_ADDR[i*16 +: 16];
            act_data   = PROC_MEM_DATA_W[i*16 +: 16];
         end
      end
   end

`ifdef PROC_WATCHDOG_EN
   logic [16:0] wdt_q;
   assign wdt_hit = (state_q == ST_RUN) && !act_mem_en && !act_draw &&
                    (wdt_q == 17'(WDT_CYCLES - 1));
   always_ff @(posedge CLK) begin
      if (RESET || state_q != ST_RUN || state_d != ST_RUN || act_mem_en || act_draw)
         wdt_q <= '0;
      else
         wdt_q <= wdt_q + 17'd1;
   end
`else
   assign wdt_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      active_d   = active_q;
      tgt_d      = tgt_q;
      error_d    = error_q;
      drain_d    = drain_q;
      open_d     = open_q;
      MEM_ENABLE = 1'b0;
      MEM_WRITE  = 1'b0;
      MEM_ADDR   = '0;
      MEM_DATA_W = '0;
      GPU_DRAW   = 1'b0;
      INT_IACK   = 1'b0;
      INT_IEND   = 1'b0;
      IRQ_HOLD   = 1'b1;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            IRQ_HOLD   = 1'b0;
            MEM_ENABLE = act_mem_en;
            MEM_WRITE  = act_mem_wr;
            MEM_ADDR   = act_addr;
            MEM_DATA_W = act_data;
            GPU_DRAW   = act_draw;
            INT_IACK   = act_iack;
            INT_IEND   = act_iend;
            if (act_iack) open_d = 1'b1;
            if (act_iend) open_d = 1'b0;
            if (act_fatal) begin
               state_d = ST_HALT;
               error_d = active_q;
            end else if (act_req) begin
               if (32'(act_tgt) >= NUM_PROC) begin
                  state_d = ST_HALT;
                  error_d = active_q;
               end else if (act_tgt != active_q) begin
                  tgt_d   = act_tgt;
                  drain_d = 4'(DRAIN_CYCLES);
                  state_d = ST_DRAIN;
               end
            end else if (wdt_hit) begin
               state_d = ST_HALT;
               error_d = active_q;
            end
         end
         ST_DRAIN: begin
            // Close an interrupt left open by the outgoing processor
            if (drain_q == 4'(DRAIN_CYCLES) && open_q) begin
               INT_IEND = 1'b1;
               open_d   = 1'b0;
            end
            if (drain_q == 4'd1) state_d = ST_SWAP;
            else drain_d = drain_q - 4'd1;
         end
         ST_SWAP: begin
            active_d = tgt_q;
            state_d  = ST_RUN;
         end
         ST_HALT: ;
         default: state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= ST_BOOT;
         active_q <= ID_W'(BOOT_ID);
         tgt_q    <= '0;
         error_q  <= '0;
         drain_q  <= '0;
         open_q   <= 1'b0;
         enable_q <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         tgt_q    <= tgt_d;
         error_q  <= error_d;
         drain_q  <= drain_d;
         open_q   <= open_d;
         enable_q <= (state_d == ST_RUN) ? (NUM_PROC'(1) << active_d) : '0;
      end
   end

   assign PROC_ENABLE = enable_q;
   assign ACTIVE_ID   = active_q;
   assign ERROR_ID    = error_q;
   assign HALTED      = (state_q == ST_HALT);
   assign STATE_DBG   = state_q;
endmodule

// File: tb/tb_processor_switcher.sv
// Directed bench for processor_switcher: a 4-processor instance and a 3-processor instance for the out-of-range target.
module tb_processor_switcher;
   logic        clk = 1'b0;
   logic        rst, rst3;
   logic [3:0]  p_en, req, fatal, mem_en, mem_wr, draw, iack, iend;
   logic [7:0]  tgt;
   logic [63:0] addr, data;
   logic        m_en, m_wr, g_draw, i_iack, i_iend, irq_hold, halted;
   logic [15:0] m_addr, m_data;
   logic [1:0]  act_id, err_id;
   logic [2:0]  st_dbg;
   logic [2:0]  p_en3, req3;
   logic [5:0]  tgt3;
   logic        m_en3, m_wr3, g_draw3, i_iack3, i_iend3, irq_hold3, halted3;
   logic [15:0] m_addr3, m_data3;
   logic [1:0]  act_id3, err_id3;
   logic [2:0]  st_dbg3;
   int          n_cmp = 0;
   int          n_err = 0;

   processor_switcher #(.NUM_PROC(4), .ID_W(2), .BOOT_ID(0), .DRAIN_CYCLES(2)) dut (
      .CLK(clk), .RESET(rst), .PROC_ENABLE(p_en), .PROC_SWITCH_REQ(req), .PROC_SWITCH_TGT(tgt),
      .PROC_FATAL(fatal), .PROC_MEM_ENABLE(mem_en), .PROC_MEM_WRITE(mem_wr), .PROC_MEM_ADDR(addr),
      .PROC_MEM_DATA_W(data), .MEM_ENABLE(m_en), .MEM_WRITE(m_wr), .MEM_ADDR(m_addr),
      .MEM_DATA_W(m_data), .PROC_GPU_DRAW(draw), .GPU_DRAW(g_draw), .PROC_INT_IACK(iack),
      .PROC_INT_IEND(iend), .INT_IACK(i_iack), .INT_IEND(i_iend), .IRQ_HOLD(irq_hold),
      .ACTIVE_ID(act_id), .HALTED(halted), .ERROR_ID(err_id), .STATE_DBG(st_dbg));

   processor_switcher #(.NUM_PROC(3), .ID_W(2), .BOOT_ID(0), .DRAIN_CYCLES(2)) dut3 (
      .CLK(clk), .RESET(rst3), .PROC_ENABLE(p_en3), .PROC_SWITCH_REQ(req3), .PROC_SWITCH_TGT(tgt3),
      .PROC_FATAL(3'b000), .PROC_MEM_ENABLE(3'b000), .PROC_MEM_WRITE(3'b000), .PROC_MEM_ADDR(48'h0),
      .PROC_MEM_DATA_W(48'h0), .MEM_ENABLE(m_en3), .MEM_WRITE(m_wr3), .MEM_ADDR(m_addr3),
      .MEM_DATA_W(m_data3), .PROC_GPU_DRAW(3'b000), .GPU_DRAW(g_draw3), .PROC_INT_IACK(3'b000),
      .PROC_INT_IEND(3'b000), .INT_IACK(i_iack3), .INT_IEND(i_iend3), .IRQ_HOLD(irq_hold3),
      .ACTIVE_ID(act_id3), .HALTED(halted3), .ERROR_ID(err_id3), .STATE_DBG(st_dbg3));

   // Clock and reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running want done");
      $fatal(1);
   end

   // Driver tasks: every drive and check happens 1 time unit after a rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req = '0; tgt = '0; fatal = '0; mem_en = '0; mem_wr = '0;
      draw = '0; iack = '0; iend = '0; addr = '0; data = '0;
   endtask

   task automatic reset_to_run();
      clear_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic do_switch(input int src, input logic [1:0] t);
      req = 4'b0001 << src;
      tgt = {4{t}};
      step();
      req = '0;
      step(); step(); step();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      addr[15:0] = 16'h0800;
      mem_en = 4'b0001;
      step(); step();
      n_cmp++; if (p_en !== 4'b0000) begin n_err++; $display("FAIL rst_en: got %b want 0000", p_en); end
      n_cmp++; if (irq_hold !== 1'b1 || halted !== 1'b0 || act_id !== 2'd0 || err_id !== 2'd0) begin
         n_err++; $display("FAIL rst_flags: got hold=%b halt=%b act=%0d err=%0d want 1 0 0 0", irq_hold, halted, act_id, err_id); end
      n_cmp++; if (m_addr !== 16'h0 || m_en !== 1'b0) begin n_err++; $display("FAIL rst_mem: got %h/%b want 0000/0", m_addr, m_en); end
      rst = 1'b0;
      step();
      n_cmp++; if (p_en !== 4'b0001 || irq_hold !== 1'b0) begin n_err++; $display("FAIL boot_run: got en=%b hold=%b want 0001 0", p_en, irq_hold); end
      n_cmp++; if (m_addr !== 16'h0800 || m_en !== 1'b1) begin n_err++; $display("FAIL boot_mem: got %h/%b want 0800/1", m_addr, m_en); end
      addr[31:16] = 16'h0900; mem_en = 4'b0011; mem_wr = 4'b0001; data[15:0] = 16'hBEEF; draw = 4'b0010;
      #1;
      n_cmp++; if (m_data !== 16'hBEEF || m_wr !== 1'b1 || m_addr !== 16'h0800 || g_draw !== 1'b0) begin
         n_err++; $display("FAIL mux_p0: got d=%h w=%b a=%h g=%b want beef 1 0800 0", m_data, m_wr, m_addr, g_draw); end
   endtask

   task automatic test_switch();
      clear_inputs();
      addr[47:32] = 16'h0A00; mem_en = 4'b0100;
      req = 4'b0001; tgt[1:0] = 2'd2;
      #1;
      n_cmp++; if (p_en !== 4'b0001 || m_en !== 1'b0) begin n_err++; $display("FAIL sw_n: got en=%b men=%b want 0001 0", p_en, m_en); end
      step();
      req = '0;
      n_cmp++; if (p_en !== 4'b0000 || irq_hold !== 1'b1 || m_addr !== 16'h0) begin
         n_err++; $display("FAIL sw_n1: got en=%b hold=%b a=%h want 0000 1 0000", p_en, irq_hold, m_addr); end
      step();
      n_cmp++; if (p_en !== 4'b0000) begin n_err++; $display("FAIL sw_n2: got %b want 0000", p_en); end
      step();
      n_cmp++; if (p_en !== 4'b0000 || act_id !== 2'd0) begin n_err++; $display("FAIL sw_n3: got en=%b act=%0d want 0000 0", p_en, act_id); end
      step();
      n_cmp++; if (p_en !== 4'b0100 || act_id !== 2'd2 || irq_hold !== 1'b0) begin
         n_err++; $display("FAIL sw_n4: got en=%b act=%0d hold=%b want 0100 2 0", p_en, act_id, irq_hold); end
      n_cmp++; if (m_addr !== 16'h0A00 || m_en !== 1'b1) begin n_err++; $display("FAIL sw_mem: got %h/%b want 0a00/1", m_addr, m_en); end
   endtask

   task automatic test_fatal_active2();
      clear_inputs();
      fatal = 4'b0100;
      step();
      fatal = '0;
      n_cmp++; if (halted !== 1'b1 || err_id !== 2'd2 || p_en !== 4'b0000) begin
         n_err++; $display("FAIL fatal2: got halt=%b err=%0d en=%b want 1 2 0000", halted, err_id, p_en); end
      req = 4'b0100; tgt[5:4] = 2'd1;
      step(); req = '0; step(); step(); step();
      n_cmp++; if (halted !== 1'b1 || p_en !== 4'b0000 || act_id !== 2'd2 || irq_hold !== 1'b1) begin
         n_err++; $display("FAIL halt_sticky: got halt=%b en=%b act=%0d hold=%b want 1 0000 2 1", halted, p_en, act_id, irq_hold); end
   endtask

   task automatic test_int_open();
      int pulses;
      reset_to_run();
      iack = 4'b0001;
      #1;
      n_cmp++; if (i_iack !== 1'b1) begin n_err++; $display("FAIL iack_pass: got %b want 1", i_iack); end
      step();
      iack = '0; req = 4'b0001; tgt[1:0] = 2'd1;
      step();
      req = '0;
      n_cmp++; if (i_iend !== 1'b1) begin n_err++; $display("FAIL iend_pulse: got %b want 1", i_iend); end
      pulses = 0;
      step(); pulses += int'(i_iend);
      step(); pulses += int'(i_iend);
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL iend_extra: got %0d want 0", pulses); end
      step();
      n_cmp++; if (p_en !== 4'b0010 || act_id !== 2'd1 || i_iend !== 1'b0) begin
         n_err++; $display("FAIL int_handover: got en=%b act=%0d iend=%b want 0010 1 0", p_en, act_id, i_iend); end
   endtask

   task automatic test_int_closed();
      reset_to_run();
      iack = 4'b0001; iend = 4'b0001;
      #1;
      n_cmp++; if (i_iend !== 1'b1) begin n_err++; $display("FAIL iend_pass: got %b want 1", i_iend); end
      step();
      iack = '0; iend = '0; req = 4'b0001; tgt[1:0] = 2'd3;
      step();
      req = '0;
      n_cmp++; if (i_iend !== 1'b0) begin n_err++; $display("FAIL iend_spurious: got %b want 0", i_iend); end
      step(); step(); step();
      n_cmp++; if (p_en !== 4'b1000 || act_id !== 2'd3) begin n_err++; $display("FAIL sw_to3: got en=%b act=%0d want 1000 3", p_en, act_id); end
   endtask

   task automatic test_inactive_and_fatal();
      reset_to_run();
      fatal = 4'b0010; req = 4'b0010; tgt[3:2] = 2'd2; mem_en = 4'b0010;
      #1;
      n_cmp++; if (m_en !== 1'b0) begin n_err++; $display("FAIL inact_mem: got %b want 0", m_en); end
      step();
      clear_inputs();
      step();
      n_cmp++; if (p_en !== 4'b0001 || halted !== 1'b0) begin n_err++; $display("FAIL inact_ign: got en=%b halt=%b want 0001 0", p_en, halted); end
      req = 4'b0001; tgt[1:0] = 2'd0;
      step();
      req = '0;
      step();
      n_cmp++; if (p_en !== 4'b0001 || irq_hold !== 1'b0) begin n_err++; $display("FAIL self_sw: got en=%b hold=%b want 0001 0", p_en, irq_hold); end
      fatal = 4'b0001; req = 4'b0001; tgt[1:0] = 2'd3;
      step();
      clear_inputs();
      n_cmp++; if (halted !== 1'b1 || err_id !== 2'd0 || p_en !== 4'b0000) begin
         n_err++; $display("FAIL fatal_wins: got halt=%b err=%0d en=%b want 1 0 0000", halted, err_id, p_en); end
      step(); step(); step(); step();
      n_cmp++; if (act_id !== 2'd0 || p_en !== 4'b0000 || halted !== 1'b1) begin
         n_err++; $display("FAIL no_switch: got act=%0d en=%b halt=%b want 0 0000 1", act_id, p_en, halted); end
   endtask

   task automatic test_reset_mid_swap();
      reset_to_run();
      req = 4'b0001; tgt[1:0] = 2'd3;
      step();
      req = '0;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if (p_en !== 4'b0000 || act_id !== 2'd0) begin n_err++; $display("FAIL mid_rst: got en=%b act=%0d want 0000 0", p_en, act_id); end
      step();
      n_cmp++; if (p_en !== 4'b0001 || act_id !== 2'd0) begin n_err++; $display("FAIL mid_rst_boot: got en=%b act=%0d want 0001 0", p_en, act_id); end
   endtask

   task automatic test_back_to_back();
      reset_to_run();
      do_switch(0, 2'd1);
      req = 4'b0010; tgt[3:2] = 2'd3;
      step();
      req = '0;
      step(); step();
      n_cmp++; if (p_en !== 4'b0000) begin n_err++; $display("FAIL b2b_swap: got %b want 0000", p_en); end
      step();
      n_cmp++; if (p_en !== 4'b1000 || act_id !== 2'd3) begin n_err++; $display("FAIL b2b_run: got en=%b act=%0d want 1000 3", p_en, act_id); end
   endtask

   task automatic test_bad_target_np3();
      req3 = '0; tgt3 = '0;
      rst3 = 1'b1;
      step();
      rst3 = 1'b0;
      step();
      n_cmp++; if (p_en3 !== 3'b001) begin n_err++; $display("FAIL np3_boot: got %b want 001", p_en3); end
      req3 = 3'b001; tgt3[1:0] = 2'd3;
      step();
      req3 = '0;
      n_cmp++; if (halted3 !== 1'b1 || err_id3 !== 2'd0 || p_en3 !== 3'b000) begin
         n_err++; $display("FAIL np3_badtgt: got halt=%b err=%0d en=%b want 1 0 000", halted3, err_id3, p_en3); end
      rst3 = 1'b1;
      step();
      rst3 = 1'b0;
      step();
      n_cmp++; if (p_en3 !== 3'b001 || halted3 !== 1'b0 || act_id3 !== 2'd0) begin
         n_err++; $display("FAIL np3_rerun: got en=%b halt=%b act=%0d want 001 0 0", p_en3, halted3, act_id3); end
   endtask

   initial begin
      rst = 1'b1; rst3 = 1'b1; req3 = '0; tgt3 = '0;
      clear_inputs();
      test_reset();
      test_switch();
      test_fatal_active2();
      test_int_open();
      test_int_closed();
      test_inactive_and_fatal();
      test_reset_mid_swap();
      test_back_to_back();
      test_bad_target_np3();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
